// File: rtl/bm_drd_arb.sv
// ---------------------------------------------------------------------------
// bm_drd_arb -- three-requester DDR read arbiter.
//
// A winner is picked among the req_req lines and acknowledged with a one-cycle
// req_ack pulse. The winner then supplies a header word and an address word
// on its req_cmd lane. One read command is issued downstream, and the returned
// beats are steered to the winner with zero latency.
//
// Build option (macro BM_DRD_ARB_FIXPRIO_EN):
//   defined   -> fixed priority, requester 0 highest, then 1, then 2
//   undefined -> round-robin, the search starts after the last grant
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enb               block enable; low aborts to IDLE and clears the outputs
//   req_req[2:0]      request levels, sampled only in IDLE
//   req_ack[2:0]      one-hot grant pulse
//   req_vcmd[2:0]     command-word valid per requester
//   req_cmd[95:0]     command words, requester k on [32k+31:32k]
//   req_vin[2:0]      one-hot read-data valid to the granted requester
//   req_din[31:0]     read data, shared by all requesters
//   m_cmd_valid/rdy   downstream read command handshake
//   m_cmd_len[7:0]    burst beats minus one
//   m_cmd_addr[31:0]  burst byte address
//   m_rvalid, m_rdata downstream read beats
//   busy              high in any state other than IDLE
//   frm_last          pulse after a burst whose header carried the last flag
//   cmd_err           pulse on a header whose read flag is clear
// ---------------------------------------------------------------------------
module bm_drd_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enb,
    input  logic [2:0]  req_req,
    output logic [2:0]  req_ack,
    input  logic [2:0]  req_vcmd,
    input  logic [95:0] req_cmd,
    output logic [2:0]  req_vin,
    output logic [31:0] req_din,
    output logic        m_cmd_valid,
    input  logic        m_cmd_rdy,
    output logic [7:0]  m_cmd_len,
    output logic [31:0] m_cmd_addr,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        frm_last,
    output logic        cmd_err
);

    typedef enum logic [2:0] {IDLE, ACK, HDR, ADDR, ISSUE, DATA, GAP} state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [7:0]  r_len;
    logic        r_last;
    logic [31:0] r_addr;
    logic [7:0]  r_cnt;
    logic [2:0]  r_req_ack;
    logic        r_cmd_valid;
    logic        r_busy;
    logic        r_frm_last;
    logic        r_cmd_err;

    logic [1:0]  w_winner;
    logic [2:0]  w_grant_oh;
    logic        w_vcmd;
    logic [31:0] w_cmd_word;
    logic        w_beat;

    // ---------------- arbitration ----------------
`ifdef BM_DRD_ARB_FIXPRIO_EN
    always_comb begin
        if (req_req[0])      w_winner = 2'd0;
        else if (req_req[1]) w_winner = 2'd1;
        else                 w_winner = 2'd2;
    end
`else
    logic [1:0] r_rr_ptr;   // first requester searched on the next arbitration

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        w_winner = 2'd0;
        case (r_rr_ptr)
            2'd1:    w_winner = req_req[1] ? 2'd1 : (req_req[2] ? 2'd2 : 2'd0);
            2'd2:    w_winner = req_req[2] ? 2'd2 : (req_req[0] ? 2'd0 : 2'd1);
            default: w_winner = req_req[0] ? 2'd0 : (req_req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rr_ptr <= 2'd0;
        else if (enb && r_state == ACK)
            r_rr_ptr <= (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
    end
`endif

    // ---------------- granted requester's command lane ----------------
    always_comb begin
        w_grant_oh = 3'b001 << r_grant;
        w_vcmd     = 1'b0;
        w_cmd_word = 32'd0;
        case (r_grant)
            2'd0:    begin w_vcmd = req_vcmd[0]; w_cmd_word = req_cmd[31:0];  end
            2'd1:    begin w_vcmd = req_vcmd[1]; w_cmd_word = req_cmd[63:32]; end
            2'd2:    begin w_vcmd = req_vcmd[2]; w_cmd_word = req_cmd[95:64]; end
            default: begin w_vcmd = 1'b0;        w_cmd_word = 32'd0;          end
        endcase
    end

    // Read beats bypass the registers; enb gates them at once so nothing
    // leaks out during the abort cycle.
    assign w_beat  = enb && (r_state == DATA) && m_rvalid;
    assign req_vin = w_beat ? w_grant_oh : 3'b000;
    assign req_din = w_beat ? m_rdata : 32'd0;

    // Header/address registers survive an enb abort, so the command outputs
    // are qualified by the valid register rather than taken raw.
    assign m_cmd_valid = r_cmd_valid;
    assign m_cmd_len   = r_cmd_valid ? r_len  : 8'd0;
    assign m_cmd_addr  = r_cmd_valid ? r_addr : 32'd0;
    assign req_ack     = r_req_ack;
    assign busy        = r_busy;
    assign frm_last    = r_frm_last;
    assign cmd_err     = r_cmd_err;

    // ---------------- control FSM ----------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= 2'd0;
            // NOTE: header and address are reset only here; enb low leaves
            // them untouched so the last command stays visible for debug.
            r_len       <= 8'd0;
            r_last      <= 1'b0;
            r_addr      <= 32'd0;
            r_cnt       <= 8'd0;
            r_req_ack   <= 3'b000;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_frm_last  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else if (!enb) begin
            r_state     <= IDLE;
            r_req_ack   <= 3'b000;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_frm_last  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            // Pulse outputs fall back to 0 unless a transition below sets them.
            r_req_ack  <= 3'b000;
            r_frm_last <= 1'b0;
            r_cmd_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req_req) begin
                        r_grant   <= w_winner;
                        r_req_ack <= 3'b001 << w_winner;
                        r_busy    <= 1'b1;
                        r_state   <= ACK;
                    end
                end
                ACK, HDR: begin
                    // The header may already be present in the ACK cycle.
                    if (w_vcmd) begin
                        r_len  <= w_cmd_word[7:0];
                        r_last <= w_cmd_word[9];
                        if (!w_cmd_word[8]) begin
                            r_cmd_err <= 1'b1;
                            r_state   <= GAP;
                        end else begin
                            r_state <= ADDR;
                        end
                    end else begin
                        r_state <= HDR;
                    end
                end
                ADDR: begin
                    if (w_vcmd) begin
                        r_addr      <= w_cmd_word;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_cmd_rdy) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= 8'd0;
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        // Compare before incrementing so len 255 never wraps.
                        if (r_cnt == r_len) begin
                            r_frm_last <= r_last;
                            r_state    <= GAP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bm_drd_arb.sv
// ---------------------------------------------------------------------------
// tb_bm_drd_arb -- scoreboard bench for bm_drd_arb.
// The driver pushes expected grants, commands, beats and pulses into queues.
// A negedge monitor pops an entry whenever the DUT presents the matching
// output and compares it against the popped entry.
// ---------------------------------------------------------------------------
module tb_bm_drd_arb;

    localparam int M_NORMAL      = 0;
    localparam int M_ABORT_ENB   = 1;
    localparam int M_RESET_ISSUE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enb;
    logic [2:0]  req_req;
    logic [2:0]  req_ack;
    logic [2:0]  req_vcmd;
    logic [95:0] req_cmd;
    logic [2:0]  req_vin;
    logic [31:0] req_din;
    logic        m_cmd_valid;
    logic        m_cmd_rdy;
    logic [7:0]  m_cmd_len;
    logic [31:0] m_cmd_addr;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        busy;
    logic        frm_last;
    logic        cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    int          exp_ack_q[$];
    logic [39:0] exp_cmd_q[$];
    logic [34:0] exp_beat_q[$];
    int          exp_frm_q[$];
    int          exp_err_q[$];

    bm_drd_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enb         (enb),
        .req_req     (req_req),
        .req_ack     (req_ack),
        .req_vcmd    (req_vcmd),
        .req_cmd     (req_cmd),
        .req_vin     (req_vin),
        .req_din     (req_din),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_rdy   (m_cmd_rdy),
        .m_cmd_len   (m_cmd_len),
        .m_cmd_addr  (m_cmd_addr),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .busy        (busy),
        .frm_last    (frm_last),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] oh(input int k);
        return 3'b001 << k;
    endfunction

    function automatic logic [95:0] lane(input int k, input logic [31:0] w);
        return 96'(w) << (32 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (req_ack != 3'b000) begin
            if (exp_ack_q.size() == 0) check("ack_unexpected", 64'(req_ack), 64'd0);
            else check("ack", 64'(req_ack), 64'(oh(exp_ack_q.pop_front())));
        end
        if (m_cmd_valid && m_cmd_rdy) begin
            if (exp_cmd_q.size() == 0) check("cmd_unexpected", {24'd0, m_cmd_len, m_cmd_addr}, 64'd0);
            else check("cmd", {24'd0, m_cmd_len, m_cmd_addr}, 64'(exp_cmd_q.pop_front()));
        end
        if (req_vin != 3'b000 || req_din != 32'd0) begin
            if (exp_beat_q.size() == 0) check("beat_unexpected", {29'd0, req_vin, req_din}, 64'd0);
            else check("beat", {29'd0, req_vin, req_din}, 64'(exp_beat_q.pop_front()));
        end
        if (frm_last) begin
            check("frm_last_expected", 64'(exp_frm_q.size() > 0), 64'd1);
            if (exp_frm_q.size() > 0) void'(exp_frm_q.pop_front());
        end
        if (cmd_err) begin
            check("cmd_err_expected", 64'(exp_err_q.size() > 0), 64'd1);
            if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
        end
    end

    // ---------------- one requester transaction ----------------
    task automatic do_burst(input int k, input logic [31:0] hdr, input logic [31:0] addr,
                            input int rdy_dly, input bit early, input logic [2:0] req_during,
                            input logic [2:0] req_after, input int mode);
        logic [31:0] h;
        int          len;
        bit          rd;
        bit          lst;
        bit          got;
        int          o;
        h   = hdr;
        len = int'(h[7:0]);
        rd  = h[8];
        lst = h[9];
        o   = (k + 1) % 3;
        got = 1'b0;

        tick();
        exp_ack_q.push_back(k);
        if (!rd) exp_err_q.push_back(k);
        req_req = req_during;
        if (early) begin
            req_vcmd = oh(k);
            req_cmd  = lane(k, hdr);
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ack != 3'b000) got = 1'b1;
        end
        if (!got) check("ack_timeout", 64'(req_ack), 64'(oh(k)));

        tick();
        if (!early) begin
            req_vcmd = oh(k);
            req_cmd  = lane(k, hdr);
            tick();
        end

        if (!rd) begin
            req_vcmd = 3'b000;
            req_cmd  = '0;
            req_req  = req_after;
            @(negedge clk);
            check("err_gap_busy", 64'(busy), 64'd1);
            check("err_no_cmd", 64'(m_cmd_valid), 64'd0);
            tick();
            @(negedge clk);
            check("err_idle_busy", 64'(busy), 64'd0);
            return;
        end

        // A word from a non-granted requester must be ignored in ADDR.
        req_vcmd = oh(o);
        req_cmd  = lane(o, 32'hDEAD_BEEF);
        tick();
        req_vcmd = oh(k);
        req_cmd  = lane(k, addr);
        tick();
        req_vcmd = 3'b000;
        req_cmd  = '0;
        req_req  = req_after;

        if (mode == M_RESET_ISSUE) begin
            @(negedge clk);
            check("rst_pre_valid", 64'(m_cmd_valid), 64'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_ack",   64'(req_ack),     64'd0);
            check("rst_vin",   64'(req_vin),     64'd0);
            check("rst_din",   64'(req_din),     64'd0);
            check("rst_valid", 64'(m_cmd_valid), 64'd0);
            check("rst_len",   64'(m_cmd_len),   64'd0);
            check("rst_addr",  64'(m_cmd_addr),  64'd0);
            check("rst_busy",  64'(busy),        64'd0);
            check("rst_frm",   64'(frm_last),    64'd0);
            check("rst_err",   64'(cmd_err),     64'd0);
            #10 rst_n = 1'b1;
            @(negedge clk);
            check("rst_idle_busy",  64'(busy),        64'd0);
            check("rst_idle_valid", 64'(m_cmd_valid), 64'd0);
            return;
        end

        for (int d = 0; d < rdy_dly; d++) begin
            @(negedge clk);
            check("issue_hold_valid", 64'(m_cmd_valid), 64'd1);
            check("issue_hold_len",   64'(m_cmd_len),   64'(h[7:0]));
            check("issue_hold_addr",  64'(m_cmd_addr),  64'(addr));
            tick();
        end
        exp_cmd_q.push_back({h[7:0], addr});
        m_cmd_rdy = 1'b1;
        tick();
        m_cmd_rdy = 1'b0;

        for (int i = 0; i <= len; i++) begin
            if (i == 3) begin
                m_rvalid = 1'b0;
                tick();
            end
            if (mode == M_ABORT_ENB && i == 5) begin
                enb      = 1'b0;
                m_rvalid = 1'b1;
                m_rdata  = 32'hBAD0_0005;
                tick();
                enb = 1'b1;
                @(negedge clk);
                check("abort_busy",  64'(busy),        64'd0);
                check("abort_valid", 64'(m_cmd_valid), 64'd0);
                tick();
                m_rvalid = 1'b0;
                return;
            end
            m_rvalid = 1'b1;
            m_rdata  = 32'hA000_0000 | (32'(k) << 16) | 32'(i);
            exp_beat_q.push_back({oh(k), m_rdata});
            tick();
        end
        if (lst) exp_frm_q.push_back(k);
        // A stray beat during GAP must not reach any requester.
        m_rvalid = 1'b1;
        m_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        check("gap_busy", 64'(busy),     64'd1);
        check("gap_frm",  64'(frm_last), 64'(lst));
        tick();
        m_rvalid = 1'b0;
        m_rdata  = 32'd0;
        @(negedge clk);
        check("idle_busy", 64'(busy),     64'd0);
        check("idle_frm",  64'(frm_last), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int order[$];
        rst_n     = 1'b0;
        enb       = 1'b1;
        req_req   = 3'b000;
        req_vcmd  = 3'b000;
        req_cmd   = '0;
        m_cmd_rdy = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'd0;

        #3;
        check("reset_ack",   64'(req_ack),     64'd0);
        check("reset_vin",   64'(req_vin),     64'd0);
        check("reset_valid", 64'(m_cmd_valid), 64'd0);
        check("reset_busy",  64'(busy),        64'd0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req_busy", 64'(busy), 64'd0);

        // Requester 1, delayed accept, 16 beats, no last flag.
        do_burst(1, 32'h0000_010F, 32'h1234_0000, 3, 1'b0, 3'b010, 3'b000, M_NORMAL);
        // Header in the ACK cycle, last flag set, 8 beats.
        do_burst(2, 32'h0000_0307, 32'h8000_0040, 1, 1'b1, 3'b100, 3'b000, M_NORMAL);
        // Read flag clear -> cmd_err, no command.
        do_burst(0, 32'h0000_0007, 32'h0000_0000, 0, 1'b0, 3'b001, 3'b000, M_NORMAL);
        // Asynchronous reset while the command is pending.
        do_burst(2, 32'h0000_0104, 32'h5555_0000, 0, 1'b0, 3'b100, 3'b000, M_RESET_ISSUE);

        // All three requests held; pointer is back at 0 after the reset.
`ifdef BM_DRD_ARB_FIXPRIO_EN
        order = '{0, 0, 0};
`else
        order = '{0, 1, 2, 0};
`endif
        foreach (order[i])
            do_burst(order[i], 32'h0000_0101, 32'h1000_0000 + 32'(i) * 32'h100, 0, 1'b0,
                     3'b111, (i == order.size() - 1) ? 3'b000 : 3'b111, M_NORMAL);

        // enb abort after 5 of 32 beats, then a normal 1-beat request.
        do_burst(0, 32'h0000_011F, 32'h2000_0000, 0, 1'b0, 3'b001, 3'b000, M_ABORT_ENB);
        do_burst(1, 32'h0000_0100, 32'h3000_0000, 1, 1'b0, 3'b010, 3'b000, M_NORMAL);
        // Longest burst, 256 beats, last flag set.
        do_burst(2, 32'h0000_03FF, 32'h4000_0000, 0, 1'b1, 3'b100, 3'b000, M_NORMAL);

        repeat (3) @(negedge clk);
        check("left_ack",  64'(exp_ack_q.size()),  64'd0);
        check("left_cmd",  64'(exp_cmd_q.size()),  64'd0);
        check("left_beat", 64'(exp_beat_q.size()), 64'd0);
        check("left_frm",  64'(exp_frm_q.size()),  64'd0);
        check("left_err",  64'(exp_err_q.size()),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
